// File: rtl/buffer_ctrl.sv
// rtl/buffer_ctrl.sv - sequencing controller sharing data_buffer between host and USB sides
module buffer_ctrl #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [6:0] buffer_occupancy,
    input  logic       host_wr_req,
    input  logic       host_rd_req,
    input  logic       host_clear,
    input  logic       rx_start,
    input  logic       rx_byte_valid,
    input  logic       rx_done,
    input  logic       rx_error,
    input  logic       tx_start,
    input  logic       tx_byte_req,
    input  logic       tx_done,
    output logic       store_tx_data,
    output logic       get_rx_data,
    output logic       store_rx_packet_data,
    output logic       get_tx_packet_data,
    output logic       clear,
    output logic       flush,
    output logic       host_wait,
    output logic       rx_data_ready,
    output logic [6:0] packet_size,
    output logic       rx_overflow,
    output logic       tx_underrun,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_LOAD = 3'd1,
        TX_SEND = 3'd2,
        RX_RECV = 3'd3,
        RX_READ = 3'd4,
        ABORT   = 3'd5
    } state_t;

    localparam logic [6:0] FULL = 7'(DEPTH);

    state_t     state, state_next;
    logic [6:0] rx_count, count_next, size_next, count_inc;
    logic       ovf_next, unr_next;
    logic       buf_full, buf_empty;

    assign buf_full  = (buffer_occupancy >= FULL);
    assign buf_empty = (buffer_occupancy == 7'd0);
    assign count_inc = (rx_count >= FULL) ? FULL : rx_count + 7'd1;

    always_comb begin
        state_next           = state;
        count_next           = rx_count;
        size_next            = packet_size;
        ovf_next             = rx_overflow;
        unr_next             = tx_underrun;
        store_tx_data        = 1'b0;
        get_rx_data          = 1'b0;
        store_rx_packet_data = 1'b0;
        get_tx_packet_data   = 1'b0;
        clear                = 1'b0;
        flush                = 1'b0;

        if (host_clear) begin
            clear      = 1'b1;
            state_next = IDLE;
            size_next  = 7'd0;
            ovf_next   = 1'b0;
            unr_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_start) begin
                        state_next = RX_RECV;
                        count_next = 7'd0;
                    end else if (host_wr_req) begin
                        store_tx_data = 1'b1;
                        state_next    = TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    if (tx_start)
                        state_next = TX_SEND;
                    else if (host_wr_req && !buf_full)
                        store_tx_data = 1'b1;
                end
                TX_SEND: begin
                    // packet end takes precedence over a same-cycle byte request
                    if (tx_done) begin
                        state_next = IDLE;
                        flush      = !buf_empty;
                    end else if (tx_byte_req) begin
                        if (!buf_empty)
                            get_tx_packet_data = 1'b1;
                        else
                            unr_next = 1'b1;
                    end
                end
                RX_RECV: begin
                    if (rx_error) begin
                        state_next = ABORT;
                    end else begin
                        if (rx_start)
                            count_next = 7'd0;
                        if (rx_byte_valid) begin
                            if (!buf_full) begin
                                store_rx_packet_data = 1'b1;
                                count_next = rx_start ? 7'd1 : count_inc;
                            end else begin
                                ovf_next = 1'b1;
                            end
                        end
                        if (rx_done) begin
                            size_next  = count_next;
                            state_next = (count_next == 7'd0) ? IDLE : RX_READ;
                        end
                    end
                end
                RX_READ: begin
                    if (host_rd_req && !buf_empty) begin
                        get_rx_data = 1'b1;
                        if (buffer_occupancy == 7'd1)
                            state_next = IDLE;
                    end
                end
                ABORT: begin
                    flush      = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign host_wait     = (host_wr_req && !store_tx_data) || (host_rd_req && !get_rx_data);
    assign rx_data_ready = (state == RX_READ);
    assign mode          = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            rx_count    <= 7'd0;
            packet_size <= 7'd0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_next;
            rx_count    <= count_next;
            packet_size <= size_next;
            rx_overflow <= ovf_next;
            tx_underrun <= unr_next;
        end
    end

endmodule

// File: tb/tb_buffer_ctrl.sv
// tb/tb_buffer_ctrl.sv - directed self-checking bench for buffer_ctrl
module tb_buffer_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [6:0] buffer_occupancy;
    logic       host_wr_req, host_rd_req, host_clear;
    logic       rx_start, rx_byte_valid, rx_done, rx_error;
    logic       tx_start, tx_byte_req, tx_done;
    logic       store_tx_data, get_rx_data, store_rx_packet_data, get_tx_packet_data;
    logic       clear, flush, host_wait, rx_data_ready;
    logic [6:0] packet_size;
    logic       rx_overflow, tx_underrun;
    logic [2:0] mode;

    logic [6:0] occ_model;
    logic       force_full;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    // behavioural data_buffer occupancy; force_full pins it at capacity
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            occ_model <= 7'd0;
        else if (clear || flush)
            occ_model <= 7'd0;
        else
            occ_model <= occ_model + 7'(store_tx_data | store_rx_packet_data)
                                   - 7'(get_rx_data | get_tx_packet_data);
    end
    assign buffer_occupancy = force_full ? 7'd64 : occ_model;

    buffer_ctrl #(.DEPTH(64)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .buffer_occupancy     (buffer_occupancy),
        .host_wr_req          (host_wr_req),
        .host_rd_req          (host_rd_req),
        .host_clear           (host_clear),
        .rx_start             (rx_start),
        .rx_byte_valid        (rx_byte_valid),
        .rx_done              (rx_done),
        .rx_error             (rx_error),
        .tx_start             (tx_start),
        .tx_byte_req          (tx_byte_req),
        .tx_done              (tx_done),
        .store_tx_data        (store_tx_data),
        .get_rx_data          (get_rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .clear                (clear),
        .flush                (flush),
        .host_wait            (host_wait),
        .rx_data_ready        (rx_data_ready),
        .packet_size          (packet_size),
        .rx_overflow          (rx_overflow),
        .tx_underrun          (tx_underrun),
        .mode                 (mode)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic zero_in();
        host_wr_req   = 1'b0;
        host_rd_req   = 1'b0;
        host_clear    = 1'b0;
        rx_start      = 1'b0;
        rx_byte_valid = 1'b0;
        rx_done       = 1'b0;
        rx_error      = 1'b0;
        tx_start      = 1'b0;
        tx_byte_req   = 1'b0;
        tx_done       = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        zero_in();
        #1;
    endtask

    initial begin
        zero_in();
        force_full = 1'b0;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_mode", 32'(mode), 0);
        check_eq("rst_flags", 32'({store_tx_data, get_rx_data, store_rx_packet_data,
                 get_tx_packet_data, clear, flush, host_wait, rx_data_ready,
                 rx_overflow, tx_underrun}), 0);
        check_eq("rst_size", 32'(packet_size), 0);
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            host_wr_req = 1'b1; #1;
            check_eq("tx_store", 32'(store_tx_data), 1);
            check_eq("tx_load_mode", 32'(mode), (i == 0) ? 0 : 1);
            tick();
        end
        tx_start = 1'b1; #1;
        check_eq("tx_start_mode", 32'(mode), 1);
        tick();
        check_eq("tx_send_mode", 32'(mode), 2);
        for (int i = 0; i < 3; i++) begin
            tx_byte_req = 1'b1; #1;
            check_eq("tx_get", 32'(get_tx_packet_data), 1);
            tick();
        end
        check_eq("tx_underrun_pre", 32'(tx_underrun), 0);
        tx_byte_req = 1'b1; #1;
        check_eq("tx_get_empty", 32'(get_tx_packet_data), 0);
        tick();
        check_eq("tx_underrun", 32'(tx_underrun), 1);
        tx_done = 1'b1; #1;
        check_eq("tx_done_flush", 32'(flush), 0);
        tick();
        check_eq("tx_done_mode", 32'(mode), 0);

        rx_start = 1'b1; host_wr_req = 1'b1; #1;
        check_eq("conflict_wait", 32'(host_wait), 1);
        check_eq("conflict_store", 32'(store_tx_data), 0);
        tick();
        check_eq("rx_recv_mode", 32'(mode), 3);
        for (int i = 0; i < 5; i++) begin
            rx_byte_valid = 1'b1; #1;
            check_eq("rx_store", 32'(store_rx_packet_data), 1);
            tick();
        end
        rx_done = 1'b1; #1;
        check_eq("rx_ready_early", 32'(rx_data_ready), 0);
        tick();
        check_eq("rx_read_mode", 32'(mode), 4);
        check_eq("rx_size", 32'(packet_size), 5);
        check_eq("rx_ready", 32'(rx_data_ready), 1);
        host_wr_req = 1'b1; #1;
        check_eq("rx_read_wr_wait", 32'(host_wait), 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            host_rd_req = 1'b1; #1;
            check_eq("rx_get", 32'(get_rx_data), 1);
            check_eq("rx_get_wait", 32'(host_wait), 0);
            tick();
            check_eq("rx_read_after", 32'(mode), (i == 4) ? 0 : 4);
        end
        check_eq("rx_ready_drop", 32'(rx_data_ready), 0);
        check_eq("underrun_sticky", 32'(tx_underrun), 1);

        rx_start = 1'b1;
        tick();
        check_eq("ovf_mode", 32'(mode), 3);
        force_full = 1'b1; rx_byte_valid = 1'b1; #1;
        check_eq("ovf_no_store", 32'(store_rx_packet_data), 0);
        tick();
        force_full = 1'b0;
        check_eq("ovf_flag", 32'(rx_overflow), 1);
        rx_byte_valid = 1'b1; #1;
        check_eq("ovf_store_after", 32'(store_rx_packet_data), 1);
        tick();
        check_eq("ovf_sticky", 32'(rx_overflow), 1);
        rx_error = 1'b1; #1;
        check_eq("err_no_flush", 32'(flush), 0);
        tick();
        check_eq("abort_mode", 32'(mode), 5);
        check_eq("abort_flush", 32'(flush), 1);
        check_eq("abort_size", 32'(packet_size), 5);
        tick();
        check_eq("abort_idle", 32'(mode), 0);
        check_eq("abort_flush_off", 32'(flush), 0);

        host_wr_req = 1'b1; #1;
        check_eq("clr_store", 32'(store_tx_data), 1);
        tick();
        force_full = 1'b1; host_wr_req = 1'b1; #1;
        check_eq("full_no_store", 32'(store_tx_data), 0);
        check_eq("full_wait", 32'(host_wait), 1);
        tick();
        force_full = 1'b0;
        tx_start = 1'b1;
        tick();
        check_eq("clr_send_mode", 32'(mode), 2);
        check_eq("clr_flags_pre", 32'({rx_overflow, tx_underrun}), 3);
        host_clear = 1'b1; tx_byte_req = 1'b1; #1;
        check_eq("clr_strobe", 32'(clear), 1);
        check_eq("clr_no_get", 32'(get_tx_packet_data), 0);
        tick();
        check_eq("clr_mode", 32'(mode), 0);
        check_eq("clr_flags", 32'({rx_overflow, tx_underrun}), 0);
        check_eq("clr_size", 32'(packet_size), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
